// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall, flush bubbling, syscall drain/halt sequencing and a retirement counter.
module pipe_ctrl_unit #(
    parameter int HALT_ON_SYSCALL = 1,
    parameter int CNT_W           = 32,
    parameter int DRAIN_CYCLES    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             flush,
    input  logic             resume,
    output logic             stall_if,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src_b,
    output logic             ex_shamt_sel,
    output logic             ex_signed_ext,
    output logic             ex_beq,
    output logic             ex_bne,
    output logic             ex_blez,
    output logic             ex_jmp,
    output logic             ex_jr,
    output logic [4:0]       ex_dst,
    output logic             mem_write,
    output logic [1:0]       mem_ram_sel,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic             wb_jal,
    output logic [4:0]       wb_dst,
    output logic             wb_syscall,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRA  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    localparam logic [1:0] RAM_WORD = 2'b00;
    localparam logic [1:0] RAM_BYTE = 2'b10;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam int             DW         = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam bit             HALT_EN    = (HALT_ON_SYSCALL != 0);

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic       alu_src_b;
        logic       shamt_sel;
        logic       signed_ext;
        logic       beq;
        logic       bne;
        logic       blez;
        logic       jmp;
        logic       jr;
        logic [4:0] dst;
        logic       mem_write;
        logic [1:0] ram_sel;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jal;
        logic       syscall;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       mem_write;
        logic [1:0] ram_sel;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jal;
        logic       syscall;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jal;
        logic       syscall;
    } mem_wb_t;

    id_ex_t         dec;
    id_ex_t         id_ex;
    ex_mem_t        ex_mem, ex_mem_d;
    mem_wb_t        mem_wb, mem_wb_d;
    logic           r_alu;
    logic           uses_rt;
    logic           load_use;
    logic           in_run;
    logic           issue;
    logic [1:0]     state;
    logic [DW-1:0]  drain_cnt;

    // ID decode; dst defaults to rt and is overridden for R-type ALU ops and JAL
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        r_alu     = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_SLL:     begin dec.alu_op = ALU_SLL;  r_alu = 1'b1; end
                    FN_SRL:     begin dec.alu_op = ALU_SRL;  r_alu = 1'b1; end
                    FN_SRA:     begin dec.alu_op = ALU_SRA;  r_alu = 1'b1; end
                    FN_SRLV:    begin dec.alu_op = ALU_SRL;  r_alu = 1'b1; dec.shamt_sel = 1'b1; end
                    FN_ADD:     begin dec.alu_op = ALU_ADD;  r_alu = 1'b1; end
                    FN_ADDU:    begin dec.alu_op = ALU_ADD;  r_alu = 1'b1; end
                    FN_SUB:     begin dec.alu_op = ALU_SUB;  r_alu = 1'b1; end
                    FN_AND:     begin dec.alu_op = ALU_AND;  r_alu = 1'b1; end
                    FN_OR:      begin dec.alu_op = ALU_OR;   r_alu = 1'b1; end
                    FN_XOR:     begin dec.alu_op = ALU_XOR;  r_alu = 1'b1; end
                    FN_NOR:     begin dec.alu_op = ALU_NOR;  r_alu = 1'b1; end
                    FN_SLT:     begin dec.alu_op = ALU_SLT;  r_alu = 1'b1; end
                    FN_SLTU:    begin dec.alu_op = ALU_SLTU; r_alu = 1'b1; end
                    FN_JR:      dec.jr = 1'b1;
                    FN_SYSCALL: dec.syscall = 1'b1;
                    default:    ;
                endcase
            end
            OP_J:   dec.jmp = 1'b1;
            OP_JAL: begin
                dec.jmp       = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec.beq        = 1'b1;
                dec.signed_ext = 1'b1;
            end
            OP_BNE: begin
                dec.bne        = 1'b1;
                dec.signed_ext = 1'b1;
            end
            OP_BLEZ: begin
                if (rt == 5'd0) begin
                    dec.blez   = 1'b1;
                    dec.alu_op = ALU_SLT;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec.alu_src_b  = 1'b1;
                dec.reg_write  = 1'b1;
                dec.signed_ext = (op == OP_ADDI) || (op == OP_SLTI);
                case (op)
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LBU: begin
                dec.alu_op     = ALU_ADD;
                dec.alu_src_b  = 1'b1;
                dec.signed_ext = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.ram_sel    = (op == OP_LBU) ? RAM_BYTE : RAM_WORD;
            end
            OP_SW: begin
                dec.alu_op     = ALU_ADD;
                dec.alu_src_b  = 1'b1;
                dec.signed_ext = 1'b1;
                dec.mem_write  = 1'b1;
            end
            default: ;
        endcase
        dec.reg_write = dec.reg_write | r_alu;
        if (r_alu)
            dec.dst = rd;
        else if (dec.jal)
            dec.dst = 5'd31;
        else
            dec.dst = rt;
    end

    // A load in EX blocks a dependent consumer in ID; rt is only a source for these formats
    always_comb begin
        uses_rt  = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        load_use = id_valid && id_ex.valid && id_ex.mem_to_reg && (id_ex.dst != 5'd0) &&
                   ((id_ex.dst == rs) || (uses_rt && (id_ex.dst == rt)));
        in_run   = (state == ST_RUN);
        issue    = in_run && id_valid && !flush && !load_use;
        stall_if = !in_run || (!flush && load_use);
    end

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.valid      = id_ex.valid;
        ex_mem_d.dst        = id_ex.dst;
        ex_mem_d.mem_write  = id_ex.mem_write;
        ex_mem_d.ram_sel    = id_ex.ram_sel;
        ex_mem_d.reg_write  = id_ex.reg_write;
        ex_mem_d.mem_to_reg = id_ex.mem_to_reg;
        ex_mem_d.jal        = id_ex.jal;
        ex_mem_d.syscall    = id_ex.syscall;

        mem_wb_d            = '0;
        mem_wb_d.valid      = ex_mem.valid;
        mem_wb_d.dst        = ex_mem.dst;
        mem_wb_d.reg_write  = ex_mem.reg_write;
        mem_wb_d.mem_to_reg = ex_mem.mem_to_reg;
        mem_wb_d.jal        = ex_mem.jal;
        mem_wb_d.syscall    = ex_mem.syscall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= issue ? dec : '0;
            ex_mem <= ex_mem_d;
            mem_wb <= mem_wb_d;
        end
    end

    // The drain counter tracks the syscall's trip to WB; it reads 0 in the cycle it retires
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (HALT_EN && issue && dec.syscall) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0)
                        state <= ST_HALT;
                    else
                        drain_cnt <= drain_cnt - 1'b1;
                end
                ST_HALT: begin
                    if (resume)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            retired_cnt <= '0;
        else if (mem_wb.valid && (state != ST_HALT))
            retired_cnt <= retired_cnt + 1'b1;
    end

    assign halted        = (state == ST_HALT);
    assign ex_alu_op     = id_ex.alu_op;
    assign ex_alu_src_b  = id_ex.alu_src_b;
    assign ex_shamt_sel  = id_ex.shamt_sel;
    assign ex_signed_ext = id_ex.signed_ext;
    assign ex_beq        = id_ex.beq;
    assign ex_bne        = id_ex.bne;
    assign ex_blez       = id_ex.blez;
    assign ex_jmp        = id_ex.jmp;
    assign ex_jr         = id_ex.jr;
    assign ex_dst        = id_ex.dst;
    assign mem_write     = ex_mem.mem_write;
    assign mem_ram_sel   = ex_mem.ram_sel;
    assign wb_reg_write  = mem_wb.reg_write;
    assign wb_mem_to_reg = mem_wb.mem_to_reg;
    assign wb_jal        = mem_wb.jal;
    assign wb_dst        = mem_wb.dst;
    assign wb_syscall    = mem_wb.syscall;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a halting instance checked stage by stage every cycle,
// plus a non-halting CNT_W=4 instance for pass-through syscalls and counter wrap.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst, id_valid, flush, resume;
    logic [5:0] op, func;
    logic [4:0] rs, rt, rd;

    logic       a_stall_if, a_alu_src_b, a_shamt_sel, a_signed_ext, a_beq, a_bne, a_blez, a_jmp, a_jr;
    logic [3:0] a_alu_op;
    logic [4:0] a_ex_dst, a_wb_dst;
    logic       a_mem_write, a_wb_reg_write, a_wb_mem_to_reg, a_wb_jal, a_wb_syscall, a_halted;
    logic [1:0] a_mem_ram_sel;
    logic [31:0] a_retired_cnt;

    logic       b_stall_if, b_alu_src_b, b_shamt_sel, b_signed_ext, b_beq, b_bne, b_blez, b_jmp, b_jr;
    logic [3:0] b_alu_op;
    logic [4:0] b_ex_dst, b_wb_dst;
    logic       b_mem_write, b_wb_reg_write, b_wb_mem_to_reg, b_wb_jal, b_wb_syscall, b_halted;
    logic [1:0] b_mem_ram_sel;
    logic [3:0] b_retired_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .flush(flush), .resume(resume), .stall_if(a_stall_if), .ex_alu_op(a_alu_op),
        .ex_alu_src_b(a_alu_src_b), .ex_shamt_sel(a_shamt_sel), .ex_signed_ext(a_signed_ext),
        .ex_beq(a_beq), .ex_bne(a_bne), .ex_blez(a_blez), .ex_jmp(a_jmp), .ex_jr(a_jr),
        .ex_dst(a_ex_dst), .mem_write(a_mem_write), .mem_ram_sel(a_mem_ram_sel),
        .wb_reg_write(a_wb_reg_write), .wb_mem_to_reg(a_wb_mem_to_reg), .wb_jal(a_wb_jal),
        .wb_dst(a_wb_dst), .wb_syscall(a_wb_syscall), .halted(a_halted), .retired_cnt(a_retired_cnt)
    );

    pipe_ctrl_unit #(.HALT_ON_SYSCALL(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .flush(flush), .resume(resume), .stall_if(b_stall_if), .ex_alu_op(b_alu_op),
        .ex_alu_src_b(b_alu_src_b), .ex_shamt_sel(b_shamt_sel), .ex_signed_ext(b_signed_ext),
        .ex_beq(b_beq), .ex_bne(b_bne), .ex_blez(b_blez), .ex_jmp(b_jmp), .ex_jr(b_jr),
        .ex_dst(b_ex_dst), .mem_write(b_mem_write), .mem_ram_sel(b_mem_ram_sel),
        .wb_reg_write(b_wb_reg_write), .wb_mem_to_reg(b_wb_mem_to_reg), .wb_jal(b_wb_jal),
        .wb_dst(b_wb_dst), .wb_syscall(b_wb_syscall), .halted(b_halted), .retired_cnt(b_retired_cnt)
    );

    logic [31:0] ex_obs, mem_obs, wb_obs;
    assign ex_obs  = {15'd0, a_alu_op, a_alu_src_b, a_shamt_sel, a_signed_ext, a_beq, a_bne,
                      a_blez, a_jmp, a_jr, a_ex_dst};
    assign mem_obs = {29'd0, a_mem_write, a_mem_ram_sel};
    assign wb_obs  = {23'd0, a_wb_reg_write, a_wb_mem_to_reg, a_wb_jal, a_wb_syscall, a_wb_dst};

    typedef struct {
        int          due;
        logic [31:0] word;
    } exp_t;

    exp_t        ex_q[$], mem_q[$], wb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        checking = 1'b0;
    logic [31:0] exp_ret  = '0;
    logic [31:0] saved_ret;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Golden control words per mnemonic, written straight from the instruction table
    function automatic void golden(input string mn, input logic [4:0] rt_i, input logic [4:0] rd_i,
                                   output logic [5:0] o_op, output logic [5:0] o_func,
                                   output logic [31:0] ex_w, output logic [31:0] mem_w,
                                   output logic [31:0] wb_w);
        logic [3:0] alu;
        logic       srcb, sh, sx, beq, bne, blez, jmp, jr, mw, rw, m2r, jal, sys;
        logic [1:0] rsel;
        logic [4:0] dst;
        {alu, srcb, sh, sx, beq, bne, blez, jmp, jr, mw, rw, m2r, jal, sys, rsel} = '0;
        o_op = 6'h00; o_func = 6'h00; dst = rt_i;
        case (mn)
            "ADD":     begin o_func = 6'h20; alu = 4'b0101; rw = 1; dst = rd_i; end
            "SUB":     begin o_func = 6'h22; alu = 4'b0110; rw = 1; dst = rd_i; end
            "NOR":     begin o_func = 6'h27; alu = 4'b1010; rw = 1; dst = rd_i; end
            "SRLV":    begin o_func = 6'h06; alu = 4'b0010; sh = 1; rw = 1; dst = rd_i; end
            "SYSCALL": begin o_func = 6'h0C; sys = 1; end
            "ADDI":    begin o_op = 6'h08; alu = 4'b0101; srcb = 1; sx = 1; rw = 1; end
            "ORI":     begin o_op = 6'h0D; alu = 4'b1000; srcb = 1; rw = 1; end
            "LW":      begin o_op = 6'h23; alu = 4'b0101; srcb = 1; sx = 1; rw = 1; m2r = 1; end
            "LBU":     begin o_op = 6'h24; alu = 4'b0101; srcb = 1; sx = 1; rw = 1; m2r = 1; rsel = 2'b10; end
            "SW":      begin o_op = 6'h2B; alu = 4'b0101; srcb = 1; sx = 1; mw = 1; end
            "BEQ":     begin o_op = 6'h04; sx = 1; beq = 1; end
            "BLEZ":    begin o_op = 6'h06; alu = 4'b1011; blez = 1; end
            "JAL":     begin o_op = 6'h03; jmp = 1; rw = 1; jal = 1; dst = 5'd31; end
            default:   $display("[TB] unknown mnemonic %s", mn);
        endcase
        ex_w  = {15'd0, alu, srcb, sh, sx, beq, bne, blez, jmp, jr, dst};
        mem_w = {29'd0, mw, rsel};
        wb_w  = {23'd0, rw, m2r, jal, sys, dst};
    endfunction

    // Holds one instruction in ID for one cycle; an issued instruction is queued for EX/MEM/WB
    task automatic applyStimulus(input string mn, input logic [4:0] rs_i, input logic [4:0] rt_i,
                                 input logic [4:0] rd_i, input logic fl, input logic exp_stall);
        logic [5:0]  g_op, g_func;
        logic [31:0] ex_w, mem_w, wb_w;
        exp_t        e;
        golden(mn, rt_i, rd_i, g_op, g_func, ex_w, mem_w, wb_w);
        id_valid = 1'b1; op = g_op; func = g_func; rs = rs_i; rt = rt_i; rd = rd_i; flush = fl;
        #1;
        checkOutput({mn, "_stall_if"}, 32'(a_stall_if), 32'(exp_stall));
        if (!exp_stall && !fl) begin
            e.due = cyc + 1; e.word = ex_w;  ex_q.push_back(e);
            e.due = cyc + 2; e.word = mem_w; mem_q.push_back(e);
            e.due = cyc + 3; e.word = wb_w;  wb_q.push_back(e);
        end
        @(posedge clk); #1;
        id_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic checkHold(input string tag, input logic exp_stall, input logic exp_halted);
        #1;
        checkOutput({tag, "_stall_if"}, 32'(a_stall_if), 32'(exp_stall));
        checkOutput({tag, "_halted"}, 32'(a_halted), 32'(exp_halted));
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        checking = 1'b0;
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; resume = 1'b0;
        op = '0; func = '0; rs = '0; rt = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        exp_ret = '0;
        checkOutput("rst_stall_if", 32'(a_stall_if), 0);
        checkOutput("rst_halted", 32'(a_halted), 0);
        checkOutput("rst_retired", a_retired_cnt, 0);
        checkOutput("rst_ex", ex_obs, 0);
        checkOutput("rst_mem", mem_obs, 0);
        checkOutput("rst_wb", wb_obs, 0);
        checkOutput("rst_b_halted", 32'(b_halted), 0);
        checkOutput("rst_b_retired", 32'(b_retired_cnt), 0);
        rst = 1'b0;
        checking = 1'b1;
    endtask

    // Scoreboard: each stage shows its queued word on the due cycle and a bubble otherwise
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("retired_cnt", a_retired_cnt, exp_ret);
            if (ex_q.size() > 0 && ex_q[0].due == cyc) begin
                checkOutput("ex_stage", ex_obs, ex_q[0].word);
                ex_q.delete(0);
            end else
                checkOutput("ex_bubble", ex_obs, 0);
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                checkOutput("mem_stage", mem_obs, mem_q[0].word);
                mem_q.delete(0);
            end else
                checkOutput("mem_bubble", mem_obs, 0);
            if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
                checkOutput("wb_stage", wb_obs, wb_q[0].word);
                wb_q.delete(0);
                exp_ret = exp_ret + 1;
            end else
                checkOutput("wb_bubble", wb_obs, 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        $display("[TB] basic ADD");
        applyStimulus("ADD", 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        idle(4);
        checkOutput("retired_after_add", a_retired_cnt, 1);

        $display("[TB] decode sweep");
        applyStimulus("SUB",  5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        applyStimulus("NOR",  5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
        applyStimulus("SRLV", 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        applyStimulus("ORI",  5'd1, 5'd6, 5'd0, 1'b0, 1'b0);
        applyStimulus("LBU",  5'd1, 5'd10, 5'd0, 1'b0, 1'b0);
        applyStimulus("SW",   5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
        applyStimulus("JAL",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus("BLEZ", 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] load-use hazards");
        applyStimulus("LW",   5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        applyStimulus("ADD",  5'd8, 5'd3, 5'd9, 1'b0, 1'b1);
        applyStimulus("ADD",  5'd8, 5'd3, 5'd9, 1'b0, 1'b0);
        idle(4);
        applyStimulus("LW",   5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        applyStimulus("SW",   5'd2, 5'd8, 5'd0, 1'b0, 1'b1);
        applyStimulus("SW",   5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        applyStimulus("LW",   5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        applyStimulus("ADDI", 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        idle(4);
        applyStimulus("LW",   5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus("ADD",  5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
        idle(4);
        applyStimulus("LW",   5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        applyStimulus("ADD",  5'd8, 5'd3, 5'd9, 1'b1, 1'b0);
        idle(4);

        $display("[TB] branch flush");
        saved_ret = exp_ret;
        applyStimulus("BEQ",  5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        applyStimulus("ADDI", 5'd3, 5'd4, 5'd0, 1'b1, 1'b0);
        idle(4);
        checkOutput("retired_only_beq", a_retired_cnt, saved_ret + 1);

        $display("[TB] syscall drain and halt");
        applyStimulus("SYSCALL", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        id_valid = 1'b1; op = 6'h00; func = 6'h20; rs = 5'd1; rt = 5'd2; rd = 5'd7;
        for (int i = 0; i < 3; i++) checkHold("drain", 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) checkHold("halt", 1'b1, 1'b1);
        resume = 1'b1;
        checkHold("resume", 1'b1, 1'b1);
        resume = 1'b0;
        applyStimulus("ADD", 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
        checkOutput("halted_after_resume", 32'(a_halted), 0);
        idle(4);

        $display("[TB] reset during drain");
        applyStimulus("SYSCALL", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        doReset();
        applyStimulus("ADDI", 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] syscall pass-through instance");
        doReset();
        checking = 1'b0;
        id_valid = 1'b1; op = 6'h00; func = 6'h0C; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        #1 checkOutput("b_sys_stall_if", 32'(b_stall_if), 0);
        @(posedge clk); #1;
        func = 6'h20; rs = 5'd1; rt = 5'd2; rd = 5'd5;
        #1 checkOutput("b_add_stall_if", 32'(b_stall_if), 0);
        @(posedge clk); #1;
        id_valid = 1'b0;
        checkOutput("b_sys_early", 32'(b_wb_syscall), 0);
        @(posedge clk); #1;
        checkOutput("b_sys_pulse", 32'(b_wb_syscall), 1);
        checkOutput("b_sys_no_write", 32'(b_wb_reg_write), 0);
        checkOutput("b_no_halt", 32'(b_halted), 0);
        checkOutput("b_no_stall", 32'(b_stall_if), 0);
        @(posedge clk); #1;
        checkOutput("b_sys_pulse_end", 32'(b_wb_syscall), 0);
        checkOutput("b_add_write", 32'(b_wb_reg_write), 1);
        checkOutput("b_add_dst", 32'(b_wb_dst), 5);
        checkOutput("b_retired_1", 32'(b_retired_cnt), 1);
        @(posedge clk); #1;
        checkOutput("b_retired_2", 32'(b_retired_cnt), 2);

        $display("[TB] counter wrap");
        doReset();
        for (int i = 0; i < 17; i++)
            applyStimulus("ADD", 5'd1, 5'd2, 5'(i + 3), 1'b0, 1'b0);
        idle(5);
        checkOutput("a_retired_17", a_retired_cnt, 17);
        checkOutput("b_retired_wrap", 32'(b_retired_cnt), 1);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
